sdram_read: RTL and testbench



---
 rtl/sdram_pkg.sv | 32 +++
 rtl/sdram_rd_capture.sv | 33 +++
 rtl/sdram_read.sv | 124 ++++++++++++
 tb/tb_sdram_read.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: commands, widths, read-engine states.
// Imported by the read engine and its capture pipeline.
package sdram_pkg;

    localparam int ADDR_W = 12;
    localparam int BANK_W = 2;
    localparam int DATA_W = 16;
    localparam int COL_W  = 9;
    localparam int CMD_W  = 4;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [CMD_W-1:0] CMD_NOP  = 4'b0111;
    localparam logic [CMD_W-1:0] CMD_ACT  = 4'b0011;
    localparam logic [CMD_W-1:0] CMD_READ = 4'b0101;
    localparam logic [CMD_W-1:0] CMD_PRE  = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_AREF = 4'b0001;

    localparam logic [ADDR_W-1:0] A10_ALL = 12'h400;

    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_ACT  = 5'b00010,
        S_RD   = 5'b00100,
        S_PRE  = 5'b01000,
        S_END  = 5'b10000
    } rd_state_t;

    function automatic logic [ADDR_W-1:0] col_addr(input logic [COL_W-1:0] c);
        return {{(ADDR_W-COL_W){1'b0}}, c};
    endfunction

endpackage

// File: rtl/sdram_rd_capture.sv
// Read data capture: delays the per-word slot pulse by CAS latency plus the
// input register, and registers sdram_dq one cycle before the valid appears.
module sdram_rd_capture
    import sdram_pkg::*;
#(
    parameter int CAS_LAT = 3
) (
    input  logic              sclk,
    input  logic              s_rst_n,
    input  logic              slot,
    input  logic [DATA_W-1:0] sdram_dq,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_vld
);

    logic [CAS_LAT:0] pipe;

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            pipe    <= '0;
            rd_data <= '0;
        end else begin
            pipe <= {pipe[CAS_LAT-1:0], slot};
            // word is on the bus now; it leaves the register next cycle
            if (pipe[CAS_LAT-1]) begin
                rd_data <= sdram_dq;
            end
        end
    end

    assign rd_data_vld = pipe[CAS_LAT];

endmodule

// File: rtl/sdram_read.sv
// SDRAM read-burst engine: ACTIVE, a run of READ bursts, PRECHARGE, with
// refresh and row-wrap breaks that keep the remaining work for the next grant.
module sdram_read
    import sdram_pkg::*;
#(
    parameter int BURST_LEN = 4,
    parameter int CAS_LAT   = 3,
    parameter int TRCD      = 2,
    parameter int TRP       = 2,
    parameter int RD_BURSTS = 4
) (
    input  logic              sclk,
    input  logic              s_rst_n,
    input  logic              rd_trig,
    input  logic              rd_en,
    input  logic              ref_req,
    output logic              rd_req,
    output logic              flag_rd_end,
    output logic [CMD_W-1:0]  rd_cmd,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [BANK_W-1:0] bank_addr,
    input  logic [DATA_W-1:0] sdram_dq,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_vld
);

    rd_state_t         state;
    logic [7:0]        cnt;
    logic [7:0]        left;
    logic [ADDR_W-1:0] row;
    logic [COL_W-1:0]  col;
    logic              slot;

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            left        <= '0;
            row         <= '0;
            col         <= '0;
            rd_req      <= 1'b0;
            flag_rd_end <= 1'b0;
            rd_cmd      <= CMD_NOP;
            rd_addr     <= '0;
        end else begin
            rd_cmd      <= CMD_NOP;
            rd_addr     <= '0;
            flag_rd_end <= 1'b0;
            cnt         <= cnt + 8'd1;
            unique case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (rd_req && rd_en) begin
                        state   <= S_ACT;
                        rd_cmd  <= CMD_ACT;
                        rd_addr <= row;
                    end else if (!rd_req && rd_trig) begin
                        rd_req <= 1'b1;
                        left   <= 8'(RD_BURSTS);
                    end
                end
                S_ACT: begin
                    if (cnt == 8'(TRCD)) begin
                        state   <= S_RD;
                        cnt     <= '0;
                        rd_cmd  <= CMD_READ;
                        rd_addr <= col_addr(col);
                        col     <= col + COL_W'(BURST_LEN);
                        left    <= left - 8'd1;
                    end
                end
                S_RD: begin
                    if (cnt == 8'(BURST_LEN - 1)) begin
                        cnt <= '0;
                        // a READ went out this slot, so col==0 means it wrapped
                        if (col == '0) begin
                            row <= row + 12'd1;
                        end
                        if (left == '0 || ref_req || col == '0) begin
                            state   <= S_PRE;
                            rd_cmd  <= CMD_PRE;
                            rd_addr <= A10_ALL;
                        end else begin
                            rd_cmd  <= CMD_READ;
                            rd_addr <= col_addr(col);
                            col     <= col + COL_W'(BURST_LEN);
                            left    <= left - 8'd1;
                        end
                    end
                end
                S_PRE: begin
                    if (cnt == 8'(TRP)) begin
                        state       <= S_END;
                        flag_rd_end <= 1'b1;
                        if (left == '0) begin
                            rd_req <= 1'b0;
                        end
                    end
                end
                S_END: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bank_addr = '0;
    assign slot      = (state == S_RD);

    sdram_rd_capture #(
        .CAS_LAT (CAS_LAT)
    ) u_capture (
        .sclk        (sclk),
        .s_rst_n     (s_rst_n),
        .slot        (slot),
        .sdram_dq    (sdram_dq),
        .rd_data     (rd_data),
        .rd_data_vld (rd_data_vld)
    );

endmodule

// File: tb/tb_sdram_read.sv
// Bench for sdram_read: cycle table for one full read, a small SDRAM data
// model with a scoreboard, and directed refresh/wrap/reset sequences.
module tb_sdram_read;

    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] ACT  = 4'b0011;
    localparam logic [3:0] RD   = 4'b0101;
    localparam logic [3:0] PRE  = 4'b0010;

    logic        sclk = 1'b0;
    logic        s_rst_n = 1'b0;
    logic        rd_trig = 1'b0;
    logic        rd_en = 1'b0;
    logic        ref_req = 1'b0;
    logic        rd_req;
    logic        flag_rd_end;
    logic [3:0]  rd_cmd;
    logic [11:0] rd_addr;
    logic [1:0]  bank_addr;
    logic [15:0] sdram_dq = 16'hDEAD;
    logic [15:0] rd_data;
    logic        rd_data_vld;

    int total = 0;
    int bad = 0;

    sdram_read dut (
        .sclk        (sclk),
        .s_rst_n     (s_rst_n),
        .rd_trig     (rd_trig),
        .rd_en       (rd_en),
        .ref_req     (ref_req),
        .rd_req      (rd_req),
        .flag_rd_end (flag_rd_end),
        .rd_cmd      (rd_cmd),
        .rd_addr     (rd_addr),
        .bank_addr   (bank_addr),
        .sdram_dq    (sdram_dq),
        .rd_data     (rd_data),
        .rd_data_vld (rd_data_vld)
    );

    always #5 sclk = ~sclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    // SDRAM model: words are {row[6:0], col+i}, driven CL cycles after READ
    typedef struct {
        int          cyc;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] sched_d[64];
    bit          sched_v[64];
    int          cyc = 0;
    logic [11:0] cur_row = '0;
    logic [11:0] act_log[$];
    logic [11:0] col_log[$];
    logic [11:0] pre_log[$];
    int          reads_cnt = 0;
    int          words = 0;
    int          flags = 0;

    function automatic logic [11:0] qat(input logic [11:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 'x;
    endfunction

    initial begin
        forever begin
            @(posedge sclk);
            cyc++;
            #1;
            if (sched_v[cyc % 64]) begin
                sdram_dq = sched_d[cyc % 64];
                sched_v[cyc % 64] = 1'b0;
            end else begin
                sdram_dq = 16'hDEAD;
            end
        end
    end

    always @(negedge sclk) begin
        if (s_rst_n) begin
            if (rd_cmd == ACT) begin
                cur_row = rd_addr;
                act_log.push_back(rd_addr);
            end
            if (rd_cmd == RD) begin
                col_log.push_back(rd_addr);
                reads_cnt++;
                for (int i = 0; i < 4; i++) begin
                    exp_t e;
                    e.data = {cur_row[6:0], 9'(rd_addr[8:0] + 9'(i))};
                    e.cyc = cyc + 4 + i;
                    sched_d[(cyc + 3 + i) % 64] = e.data;
                    sched_v[(cyc + 3 + i) % 64] = 1'b1;
                    exp_q.push_back(e);
                end
            end
            if (rd_cmd == PRE) pre_log.push_back(rd_addr);
            if (flag_rd_end) flags++;
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL vld_missing cyc=%0d exp_cyc=%0d", cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (rd_data_vld) begin
                words++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL vld_extra cyc=%0d data=%0h", cyc, rd_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("vld_cycle", cyc, e.cyc);
                    chk("rd_data", {16'h0, rd_data}, {16'h0, e.data});
                end
            end
        end
    end

    task automatic clear_logs();
        act_log.delete();
        col_log.delete();
        pre_log.delete();
        words = 0;
        flags = 0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge sclk);
        #1;
    endtask

    task automatic pulse_trig();
        @(posedge sclk);
        #1 rd_trig = 1'b1;
        @(posedge sclk);
        #1 rd_trig = 1'b0;
    endtask

    task automatic grant(input int ref_at, input int trig_at);
        int base;
        bit done;
        base = reads_cnt;
        @(posedge sclk);
        #1 rd_en = 1'b1;
        @(posedge sclk);
        #1 rd_en = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 80 && !done; i++) begin
            @(negedge sclk);
            if (ref_at > 0 && reads_cnt - base >= ref_at) ref_req = 1'b1;
            rd_trig = (trig_at > 0 && reads_cnt - base == trig_at);
            if (flag_rd_end) done = 1'b1;
        end
        rd_trig = 1'b0;
        ref_req = 1'b0;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL grant_timeout got=no_flag exp=flag_rd_end");
        end
    endtask

    typedef struct {
        bit          trig;
        bit          en;
        logic [3:0]  cmd;
        logic [11:0] addr;
        bit          req;
        bit          flag;
        bit          vld;
    } vec_t;

    vec_t tbl[27];

    initial begin
        int k;

        for (int i = 0; i < 27; i++) begin
            tbl[i] = '{trig: 1'b0, en: 1'b0, cmd: NOP, addr: 12'h0,
                       req: (i >= 1 && i <= 24), flag: 1'b0,
                       vld: (i >= 10 && i <= 25)};
        end
        tbl[0].trig = 1'b1;
        tbl[2].en   = 1'b1;
        tbl[3].cmd  = ACT;
        tbl[6].cmd  = RD;
        tbl[10].cmd = RD;
        tbl[10].addr = 12'd4;
        tbl[14].cmd = RD;
        tbl[14].addr = 12'd8;
        tbl[18].cmd = RD;
        tbl[18].addr = 12'd12;
        tbl[22].cmd = PRE;
        tbl[22].addr = 12'h400;
        tbl[25].flag = 1'b1;

        // reset idle
        repeat (3) @(negedge sclk);
        chk("rst_cmd", rd_cmd, NOP);
        chk("rst_req", rd_req, 0);
        chk("rst_vld", rd_data_vld, 0);
        chk("rst_addr", rd_addr, 0);
        chk("rst_data", rd_data, 0);
        @(posedge sclk);
        #1 s_rst_n = 1'b1;
        clear_logs();
        k = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge sclk);
            if (rd_cmd !== NOP) k++;
        end
        chk("idle_cmds", k, 0);
        chk("idle_req", rd_req, 0);
        chk("idle_words", words, 0);

        // single trigger, cycle by cycle
        clear_logs();
        for (int i = 0; i < 27; i++) begin
            @(posedge sclk);
            #1;
            rd_trig = tbl[i].trig;
            rd_en = tbl[i].en;
            @(negedge sclk);
            chk($sformatf("t%0d_cmd", i), rd_cmd, tbl[i].cmd);
            if (tbl[i].cmd != NOP) chk($sformatf("t%0d_addr", i), rd_addr, tbl[i].addr);
            chk($sformatf("t%0d_req", i), rd_req, tbl[i].req);
            chk($sformatf("t%0d_flag", i), flag_rd_end, tbl[i].flag);
            chk($sformatf("t%0d_vld", i), rd_data_vld, tbl[i].vld);
            chk($sformatf("t%0d_bank", i), bank_addr, 0);
        end
        wait_cycles(3);
        chk("single_words", words, 16);
        chk("single_flags", flags, 1);

        // reset in the middle of S_RD
        clear_logs();
        pulse_trig();
        k = reads_cnt;
        @(posedge sclk);
        #1 rd_en = 1'b1;
        @(posedge sclk);
        #1 rd_en = 1'b0;
        for (int i = 0; i < 40 && reads_cnt - k < 2; i++) @(negedge sclk);
        chk("mid_reads", reads_cnt - k, 2);
        @(posedge sclk);
        #2 s_rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_cmd", rd_cmd, NOP);
        chk("mid_addr", rd_addr, 0);
        chk("mid_req", rd_req, 0);
        chk("mid_vld", rd_data_vld, 0);
        chk("mid_data", rd_data, 0);
        chk("mid_flag", flag_rd_end, 0);
        wait_cycles(3);
        s_rst_n = 1'b1;
        clear_logs();
        wait_cycles(12);
        chk("post_rst_words", words, 0);
        chk("post_rst_acts", act_log.size(), 0);
        chk("post_rst_req", rd_req, 0);

        // refresh break during burst 2, then resume
        clear_logs();
        pulse_trig();
        grant(2, 0);
        wait_cycles(3);
        chk("ref_nreads", col_log.size(), 2);
        chk("ref_col0", qat(col_log, 0), 0);
        chk("ref_col1", qat(col_log, 1), 4);
        chk("ref_pre", qat(pre_log, 0), 12'h400);
        chk("ref_req_held", rd_req, 1);
        chk("ref_words", words, 8);
        clear_logs();
        grant(0, 0);
        wait_cycles(3);
        chk("res_row", qat(act_log, 0), 0);
        chk("res_nreads", col_log.size(), 2);
        chk("res_col0", qat(col_log, 0), 8);
        chk("res_col1", qat(col_log, 1), 12);
        chk("res_req", rd_req, 0);
        chk("res_words", words, 8);

        // trigger while busy is ignored
        clear_logs();
        pulse_trig();
        grant(0, 2);
        wait_cycles(12);
        chk("busy_words", words, 16);
        chk("busy_req", rd_req, 0);
        chk("busy_acts", act_log.size(), 1);
        chk("busy_col0", qat(col_log, 0), 16);

        // walk the column pointer up to 496
        for (int i = 0; i < 29; i++) begin
            pulse_trig();
            grant(0, 0);
        end
        wait_cycles(3);

        clear_logs();
        pulse_trig();
        grant(2, 0);
        wait_cycles(3);
        chk("wr_pre_col0", qat(col_log, 0), 496);
        chk("wr_pre_col1", qat(col_log, 1), 500);
        chk("wr_pre_req", rd_req, 1);
        clear_logs();
        grant(0, 0);
        wait_cycles(3);
        chk("wr_row0", qat(act_log, 0), 0);
        chk("wr_nreads", col_log.size(), 2);
        chk("wr_col504", qat(col_log, 0), 504);
        chk("wr_col508", qat(col_log, 1), 508);
        chk("wr_pre", qat(pre_log, 0), 12'h400);
        chk("wr_req", rd_req, 0);
        clear_logs();
        pulse_trig();
        grant(0, 0);
        wait_cycles(3);
        chk("wr_row1", qat(act_log, 0), 1);
        chk("wr_col0", qat(col_log, 0), 0);
        chk("wr_words", words, 16);
        chk("wr_left", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
